// File: rtl/instruction_fetch_pkg.sv
// Shared constants, FSM encoding and PC helpers for the RV32I instruction fetch stage.
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
    localparam int          IMEM_ADDR_W_DEFAULT = 14;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_BUBBLE = 3'd1,
        ST_RUN    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ERROR  = 3'd4
    } fetch_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    function automatic logic [31:0] clear_lsb(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFE;
    endfunction

endpackage

// File: rtl/instruction_fetch_branch_unit.sv
// Combinational branch comparator and redirect-target generator for the fetch stage.
module branch_unit
    import instruction_fetch_pkg::*;
(
    input  logic        branch_i,
    input  logic        nbranch_i,
    input  logic        blt_i,
    input  logic        bge_i,
    input  logic        bltu_i,
    input  logic        bgeu_i,
    input  logic        jal_i,
    input  logic        jalr_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] pc_i,
    output logic        taken_o,
    output logic [31:0] target_o,
    output logic        misaligned_o
);

    logic eq_s;
    logic slt_s;
    logic ult_s;

    // Operand comparisons shared by all conditional branch flavours
    always_comb begin
        eq_s  = (rs1_i == rs2_i);
        slt_s = ($signed(rs1_i) < $signed(rs2_i));
        ult_s = (rs1_i < rs2_i);
    end

    // Taken decision, target select (jalr wins) and alignment check
    always_comb begin
        taken_o = jal_i | jalr_i
                | (branch_i  &  eq_s) | (nbranch_i & ~eq_s)
                | (blt_i     &  slt_s) | (bge_i    & ~slt_s)
                | (bltu_i    &  ult_s) | (bgeu_i   & ~ult_s);
        if (jalr_i) begin
            target_o = clear_lsb(rs1_i + imm_i);
        end else begin
            target_o = pc_i + imm_i;
        end
        misaligned_o = (target_o[1:0] != 2'b00);
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the synchronous instruction BRAM and presents
// one instruction per cycle, inserting a single bubble per taken redirect.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          IMEM_ADDR_W = IMEM_ADDR_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [31:0]            imem_rdata,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic                   Branch,
    input  logic                   nBranch,
    input  logic                   branch_lt,
    input  logic                   branch_ge,
    input  logic                   branch_ltu,
    input  logic                   branch_geu,
    input  logic                   jal,
    input  logic                   jalr,
    input  logic [31:0]            rs1_data,
    input  logic [31:0]            rs2_data,
    input  logic [31:0]            imm,
    output logic [31:0]            instruction,
    output logic [31:0]            pc,
    output logic [31:0]            link_addr,
    output logic                   inst_valid,
    output logic                   fetch_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  link_q, link_d;
    logic [31:0]  hold_q, hold_d;
    logic         err_q, err_d;

    logic         taken_s;
    logic [31:0]  target_s;
    logic         misaligned_s;

    branch_unit u_branch_unit (
        .branch_i     (Branch),
        .nbranch_i    (nBranch),
        .blt_i        (branch_lt),
        .bge_i        (branch_ge),
        .bltu_i       (branch_ltu),
        .bgeu_i       (branch_geu),
        .jal_i        (jal),
        .jalr_i       (jalr),
        .rs1_i        (rs1_data),
        .rs2_i        (rs2_data),
        .imm_i        (imm),
        .pc_i         (pc_q),
        .taken_o      (taken_s),
        .target_o     (target_s),
        .misaligned_o (misaligned_s)
    );

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            link_q     <= pc_plus4(RESET_PC);
            hold_q     <= NOP_INSTR;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            link_q     <= link_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic; redirect and stall are only honoured while an instruction is live
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_BUBBLE;
            ST_BUBBLE: state_d = ST_RUN;
            ST_RUN, ST_HOLD: begin
                if (stall) begin
                    state_d = ST_HOLD;
                end else if (taken_s) begin
                    if (misaligned_s) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_BUBBLE;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_ERROR;
        endcase
    end

    // PC / hold datapath; in BUBBLE the BRAM is reading pc, so the next fetch is pc+4
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        link_d     = link_q;
        hold_d     = hold_q;
        err_d      = err_q;
        case (state_q)
            ST_BUBBLE: fetch_pc_d = pc_plus4(pc_q);
            ST_RUN, ST_HOLD: begin
                if (stall) begin
                    if (state_q == ST_RUN) begin
                        hold_d = imem_rdata;
                    end else begin
                        hold_d = hold_q;
                    end
                end else if (taken_s) begin
                    if (misaligned_s) begin
                        err_d = 1'b1;
                    end else begin
                        fetch_pc_d = target_s;
                        pc_d       = target_s;
                        link_d     = pc_plus4(target_s);
                    end
                end else begin
                    pc_d       = fetch_pc_q;
                    fetch_pc_d = pc_plus4(fetch_pc_q);
                    link_d     = pc_plus4(fetch_pc_q);
                end
            end
            default: fetch_pc_d = fetch_pc_q;
        endcase
    end

    // Output mux: live BRAM word, held word, or NOP
    always_comb begin
        instruction = NOP_INSTR;
        inst_valid  = 1'b0;
        case (state_q)
            ST_RUN: begin
                instruction = imem_rdata;
                inst_valid  = 1'b1;
            end
            ST_HOLD: begin
                instruction = hold_q;
                inst_valid  = 1'b1;
            end
            default: begin
                instruction = NOP_INSTR;
                inst_valid  = 1'b0;
            end
        endcase
    end

    assign imem_addr = fetch_pc_q[IMEM_ADDR_W+1:2];
    assign pc        = pc_q;
    assign link_addr = link_q;
    assign fetch_err = err_q;

endmodule
